// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - single-port line arbiter for ICache/DCache refill and write-buffer drain
// Optional feature macro: ARB_WB_STARVE_GUARD_EN (read-streak guard that forces a write-buffer drain)
module cache_mem_arbiter #(
  parameter int LINE_W          = 256,
  parameter int ADDR_W          = 32,
  parameter int MAX_READ_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_rreq_i,
  input  logic [ADDR_W-1:0] ic_raddr_i,
  output logic              ic_rvalid_o,
  output logic [LINE_W-1:0] ic_rdata_o,
  input  logic              dc_rreq_i,
  input  logic [ADDR_W-1:0] dc_raddr_i,
  output logic              dc_rvalid_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [LINE_W-1:0] wb_wdata_i,
  output logic              wb_bvalid_o,
  output logic              mem_rreq_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic              mem_rvalid_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              mem_wreq_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_bvalid_i
);

  // Clears the byte-within-line offset of a 32-byte line.
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-5){1'b1}}, 5'b00000};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_IC = 3'd1,
    RD_DC = 3'd2,
    WR    = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e              state_q;
  state_e              grant_d;
  logic                hazard;
  logic                starve_force;
  logic                ic_rvalid_q;
  logic                dc_rvalid_q;
  logic [LINE_W-1:0]   ic_rdata_q;
  logic [LINE_W-1:0]   dc_rdata_q;
  logic                mem_rreq_q;
  logic [ADDR_W-1:0]   mem_raddr_q;
  logic                mem_wreq_q;

  // A pending dirty line must reach memory before any read of that same line.
  always_comb begin
    hazard = wb_valid_i &&
             ((dc_rreq_i && (dc_raddr_i[ADDR_W-1:5] == wb_addr_i[ADDR_W-1:5])) ||
              (ic_rreq_i && (ic_raddr_i[ADDR_W-1:5] == wb_addr_i[ADDR_W-1:5])));
  end

`ifdef ARB_WB_STARVE_GUARD_EN
  localparam int STREAK_W = ($clog2(MAX_READ_STREAK + 1) > 3) ? $clog2(MAX_READ_STREAK + 1) : 3;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_READ_STREAK);

  logic [STREAK_W-1:0] streak_q;

  always_comb begin
    starve_force = wb_valid_i && (streak_q == STREAK_MAX);
  end

  // Count read grants made while a dirty line waits; any write grant or an empty buffer restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else if (!wb_valid_i) begin
      streak_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_d == WR) begin
        streak_q <= '0;
      end else if ((grant_d == RD_IC) || (grant_d == RD_DC)) begin
        if (streak_q != STREAK_MAX) begin
          streak_q <= streak_q + 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    starve_force = 1'b0;
  end
`endif

  // Grant selection as seen from IDLE: hazard/starvation drain, then DCache, ICache, plain drain.
  always_comb begin
    grant_d = IDLE;
    if (hazard || starve_force) begin
      grant_d = WR;
    end else if (dc_rreq_i) begin
      grant_d = RD_DC;
    end else if (ic_rreq_i) begin
      grant_d = RD_IC;
    end else if (wb_valid_i) begin
      grant_d = WR;
    end
  end

  // Transaction FSM; every request/valid output it drives is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      mem_rreq_q  <= 1'b0;
      mem_raddr_q <= '0;
      mem_wreq_q  <= 1'b0;
    end else begin
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= grant_d;
          case (grant_d)
            RD_DC: begin
              mem_rreq_q  <= 1'b1;
              mem_raddr_q <= dc_raddr_i & LINE_MASK;
            end
            RD_IC: begin
              mem_rreq_q  <= 1'b1;
              mem_raddr_q <= ic_raddr_i & LINE_MASK;
            end
            WR: begin
              mem_wreq_q <= 1'b1;
            end
            default: begin
              mem_rreq_q <= 1'b0;
              mem_wreq_q <= 1'b0;
            end
          endcase
        end
        RD_IC: begin
          if (mem_rvalid_i) begin
            mem_rreq_q  <= 1'b0;
            ic_rdata_q  <= mem_rdata_i;
            ic_rvalid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RD_DC: begin
          if (mem_rvalid_i) begin
            mem_rreq_q  <= 1'b0;
            dc_rdata_q  <= mem_rdata_i;
            dc_rvalid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        WR: begin
          if (mem_bvalid_i) begin
            mem_wreq_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        RESP: begin
          // The requester retires its request on this edge, so IDLE sees fresh inputs.
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          mem_rreq_q <= 1'b0;
          mem_wreq_q <= 1'b0;
        end
      endcase
    end
  end

  // Write data follows the buffer live so a line rewritten mid-drain is what memory sees.
  always_comb begin
    wb_bvalid_o = (state_q == WR) && mem_bvalid_i;
    mem_waddr_o = (state_q == WR) ? (wb_addr_i & LINE_MASK) : '0;
    mem_wdata_o = (state_q == WR) ? wb_wdata_i : '0;
  end

  assign ic_rvalid_o = ic_rvalid_q;
  assign dc_rvalid_o = dc_rvalid_q;
  assign ic_rdata_o  = ic_rdata_q;
  assign dc_rdata_o  = dc_rdata_q;
  assign mem_rreq_o  = mem_rreq_q;
  assign mem_raddr_o = mem_raddr_q;
  assign mem_wreq_o  = mem_wreq_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_rreq_i;
  logic [31:0]  ic_raddr_i;
  logic         ic_rvalid_o;
  logic [255:0] ic_rdata_o;
  logic         dc_rreq_i;
  logic [31:0]  dc_raddr_i;
  logic         dc_rvalid_o;
  logic [255:0] dc_rdata_o;
  logic         wb_valid_i;
  logic [31:0]  wb_addr_i;
  logic [255:0] wb_wdata_i;
  logic         wb_bvalid_o;
  logic         mem_rreq_o;
  logic [31:0]  mem_raddr_o;
  logic         mem_rvalid_i;
  logic [255:0] mem_rdata_i;
  logic         mem_wreq_o;
  logic [31:0]  mem_waddr_o;
  logic [255:0] mem_wdata_o;
  logic         mem_bvalid_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit           is_dc;
    logic [255:0] data;
  } exp_t;
  exp_t sb[$];

  cache_mem_arbiter #(.LINE_W(256), .ADDR_W(32), .MAX_READ_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .ic_rreq_i(ic_rreq_i), .ic_raddr_i(ic_raddr_i), .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o),
    .dc_rreq_i(dc_rreq_i), .dc_raddr_i(dc_raddr_i), .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_wdata_i(wb_wdata_i), .wb_bvalid_o(wb_bvalid_o),
    .mem_rreq_o(mem_rreq_o), .mem_raddr_o(mem_raddr_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_wreq_o(mem_wreq_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o), .mem_bvalid_i(mem_bvalid_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("no_rw_overlap", {255'd0, mem_rreq_o & mem_wreq_o}, 256'd0);
  endtask

  function automatic logic [255:0] line_data(input int n);
    line_data = {8{32'hDA7A_0000 + n}};
  endfunction

  // Ticks until a read or write grant appears; kind 1 = read, 2 = write, 0 = none.
  task automatic wait_grant(output int kind);
    kind = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_rreq_o) begin kind = 1; break; end
      if (mem_wreq_o) begin kind = 2; break; end
    end
    total++;
    assert (kind != 0) else begin
      bad++;
      $error("FAIL grant_timeout observed=%0d expected=nonzero", kind);
    end
  endtask

  // Called in a granted read cycle; completes it and checks the one-cycle response pulse.
  task automatic do_read(input bit is_dc, input logic [31:0] req_addr, input logic [255:0] data,
                         input bit keep, input logic [31:0] next_addr);
    exp_t e;
    chk("rd_addr", {224'd0, mem_raddr_o}, {224'd0, req_addr & 32'hFFFF_FFE0});
    sb.push_back('{is_dc, data});
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = data;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    chk("rvalid_hi", {255'd0, is_dc ? dc_rvalid_o : ic_rvalid_o}, 256'd1);
    chk("rvalid_other", {255'd0, is_dc ? ic_rvalid_o : dc_rvalid_o}, 256'd0);
    chk("rreq_dropped", {255'd0, mem_rreq_o}, 256'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rdata", e.is_dc ? dc_rdata_o : ic_rdata_o, e.data);
    end
    if (is_dc) begin dc_rreq_i = keep; dc_raddr_i = next_addr; end
    else       begin ic_rreq_i = keep; ic_raddr_i = next_addr; end
    tick();
    chk("rvalid_lo", {255'd0, is_dc ? dc_rvalid_o : ic_rvalid_o}, 256'd0);
  endtask

  // Called in a WR cycle; completes the write and releases the write buffer.
  task automatic finish_write();
    chk("wreq_hi", {255'd0, mem_wreq_o}, 256'd1);
    mem_bvalid_i = 1'b1;
    #1;
    chk("bvalid_pass", {255'd0, wb_bvalid_o}, 256'd1);
    tick();
    mem_bvalid_i = 1'b0;
    wb_valid_i   = 1'b0;
    chk("wreq_lo", {255'd0, mem_wreq_o}, 256'd0);
    chk("bvalid_lo", {255'd0, wb_bvalid_o}, 256'd0);
  endtask

  initial begin
    int kind;
    int nreads;
    bit saw_wr;
    logic [31:0] a;

    rst = 1'b1;
    ic_rreq_i = 1'b1; ic_raddr_i = 32'h0ABC_DEF4;
    dc_rreq_i = 1'b1; dc_raddr_i = 32'h1234_5678;
    wb_valid_i = 1'b1; wb_addr_i = 32'h5555_0000; wb_wdata_i = line_data(99);
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_bvalid_i = 1'b0;

    // Reset with every request high.
    tick();
    tick();
    chk("rst_rreq", {255'd0, mem_rreq_o}, 256'd0);
    chk("rst_wreq", {255'd0, mem_wreq_o}, 256'd0);
    chk("rst_rvalids", {254'd0, ic_rvalid_o, dc_rvalid_o}, 256'd0);
    chk("rst_bvalid", {255'd0, wb_bvalid_o}, 256'd0);
    chk("rst_raddr", {224'd0, mem_raddr_o}, 256'd0);
    chk("rst_waddr", {224'd0, mem_waddr_o}, 256'd0);
    chk("rst_dc_rdata", dc_rdata_o, 256'd0);
    chk("rst_ic_rdata", ic_rdata_o, 256'd0);

    // DCache wins over ICache; ICache granted after the IDLE cycle following RESP.
    rst = 1'b0;
    wb_valid_i = 1'b0;
    tick();
    chk("dc_grant", {255'd0, mem_rreq_o}, 256'd1);
    chk("dc_grant_nowr", {255'd0, mem_wreq_o}, 256'd0);
    do_read(1'b1, 32'h1234_5678, {32{8'hA5}}, 1'b0, 32'h0);
    chk("idle_gap", {255'd0, mem_rreq_o}, 256'd0);
    tick();
    chk("ic_grant", {255'd0, mem_rreq_o}, 256'd1);
    do_read(1'b0, 32'h0ABC_DEF4, line_data(2), 1'b0, 32'h0);
    chk("dc_rdata_hold", dc_rdata_o, {32{8'hA5}});

    // Read-after-write hazard on the same line drains the write buffer first.
    wb_valid_i = 1'b1; wb_addr_i = 32'h1000_0040; wb_wdata_i = line_data(3);
    dc_rreq_i = 1'b1; dc_raddr_i = 32'h1000_0058;
    tick();
    chk("hz_wreq", {255'd0, mem_wreq_o}, 256'd1);
    chk("hz_rreq", {255'd0, mem_rreq_o}, 256'd0);
    chk("hz_waddr", {224'd0, mem_waddr_o}, {224'd0, 32'h1000_0040});
    chk("hz_wdata", mem_wdata_o, line_data(3));
    chk("hz_bvalid_idle", {255'd0, wb_bvalid_o}, 256'd0);
    finish_write();
    tick();
    chk("hz_rd_grant", {255'd0, mem_rreq_o}, 256'd1);
    do_read(1'b1, 32'h1000_0040, line_data(4), 1'b0, 32'h0);

    // Non-matching dirty line waits behind an ICache read; stray write response ignored.
    wb_valid_i = 1'b1; wb_addr_i = 32'h2000_0000; wb_wdata_i = line_data(5);
    ic_rreq_i = 1'b1; ic_raddr_i = 32'h3000_0024;
    tick();
    chk("nm_rreq", {255'd0, mem_rreq_o}, 256'd1);
    chk("nm_wreq", {255'd0, mem_wreq_o}, 256'd0);
    mem_bvalid_i = 1'b1;
    #1;
    chk("spurious_bvalid", {255'd0, wb_bvalid_o}, 256'd0);
    tick();
    mem_bvalid_i = 1'b0;
    chk("nm_still_rd", {255'd0, mem_rreq_o}, 256'd1);
    do_read(1'b0, 32'h3000_0024, line_data(6), 1'b0, 32'h0);
    chk("nm_wreq_after_rd", {255'd0, mem_wreq_o}, 256'd0);
    tick();
    chk("nm_wr_grant", {255'd0, mem_wreq_o}, 256'd1);
    chk("nm_waddr", {224'd0, mem_waddr_o}, {224'd0, 32'h2000_0000});
    finish_write();

    // Continuous DCache reads while a dirty line is pending.
    wb_valid_i = 1'b1; wb_addr_i = 32'h4000_0000; wb_wdata_i = line_data(7);
    a = 32'h5000_0000;
    dc_rreq_i = 1'b1; dc_raddr_i = a;
    nreads = 0;
    saw_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_grant(kind);
      if (kind == 1) begin
        do_read(1'b1, a, line_data(10 + i), 1'b1, a + 32'h40);
        a = a + 32'h40;
        nreads++;
      end else begin
        saw_wr = (kind == 2);
        break;
      end
    end
`ifdef ARB_WB_STARVE_GUARD_EN
    chk("streak_reads", 256'(nreads), 256'd4);
    chk("streak_wr", {255'd0, saw_wr}, 256'd1);
    dc_rreq_i = 1'b0;
`else
    chk("streak_reads", 256'(nreads), 256'd8);
    chk("streak_wr", {255'd0, saw_wr}, 256'd0);
    dc_rreq_i = 1'b0;
    wait_grant(kind);
    chk("streak_late_wr", 256'(kind), 256'd2);
`endif
    chk("streak_waddr", {224'd0, mem_waddr_o}, {224'd0, 32'h4000_0000});
    finish_write();

    // Reset while a read is outstanding; late memory data must be ignored.
    ic_rreq_i = 1'b1; ic_raddr_i = 32'h6000_0010;
    wait_grant(kind);
    chk("mr_grant", 256'(kind), 256'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ic_rreq_i = 1'b0;
    chk("mr_rreq", {255'd0, mem_rreq_o}, 256'd0);
    chk("mr_raddr", {224'd0, mem_raddr_o}, 256'd0);
    chk("mr_ic_rdata", ic_rdata_o, 256'd0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = line_data(77);
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    chk("mr_no_rvalid", {255'd0, ic_rvalid_o}, 256'd0);
    tick();
    chk("mr_no_rvalid2", {255'd0, ic_rvalid_o}, 256'd0);
    chk("mr_ic_rdata2", ic_rdata_o, 256'd0);
    chk("sb_empty", 256'(sb.size()), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
